// File: rtl/csr_file_ctrl.sv
// Machine-mode CSR file with trap-entry / MRET sequencer and fetch redirect.
// Optional 64-bit mcycle/minstret counters are enabled by defining CSR_COUNTERS_EN.
module csr_file_ctrl #(
   parameter logic [31:0] HART_ID     = 32'h0,
   parameter logic [31:0] MTVEC_RESET = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] csr_addr,
   input  logic        csr_rd_en,
   input  logic        csr_wr_en,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        csr_illegal,
   input  logic        trap_req,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_pc,
   input  logic        mret_req,
   input  logic        instr_retire,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy,
   output logic        mie_global
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRAP,
      ST_MRET
   } state_e;

   state_e      state_q, state_d;
   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;
`else
   logic        unused_retire;
   assign unused_retire = instr_retire;
`endif

   logic implemented;
   logic wr_ok;

   // NOTE: every variable driven here gets a default first, so no path can infer a latch.
   always_comb begin
      csr_rdata   = 32'h0;
      implemented = 1'b0;
      case (csr_addr)
         ADDR_MSTATUS:  begin implemented = 1'b1; csr_rdata = {24'h0, mpie_q, 3'b000, mie_q, 3'b000}; end
         ADDR_MTVEC:    begin implemented = 1'b1; csr_rdata = mtvec_q;    end
         ADDR_MSCRATCH: begin implemented = 1'b1; csr_rdata = mscratch_q; end
         ADDR_MEPC:     begin implemented = 1'b1; csr_rdata = mepc_q;     end
         ADDR_MCAUSE:   begin implemented = 1'b1; csr_rdata = mcause_q;   end
         ADDR_MHARTID:  begin implemented = 1'b1; csr_rdata = HART_ID;    end
`ifdef CSR_COUNTERS_EN
         ADDR_MCYCLE:    begin implemented = 1'b1; csr_rdata = mcycle_q[31:0];    end
         ADDR_MCYCLEH:   begin implemented = 1'b1; csr_rdata = mcycle_q[63:32];   end
         ADDR_MINSTRET:  begin implemented = 1'b1; csr_rdata = minstret_q[31:0];  end
         ADDR_MINSTRETH: begin implemented = 1'b1; csr_rdata = minstret_q[63:32]; end
`endif
         default: ;
      endcase
      csr_illegal = ((csr_rd_en || csr_wr_en) && !implemented)
                 || (csr_wr_en && (csr_addr == ADDR_MHARTID));
   end

   assign wr_ok = csr_wr_en && !csr_illegal;

   always_comb begin
      state_d    = state_q;
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
`ifdef CSR_COUNTERS_EN
      // Counters advance in every state; a CSR write then overrides its half.
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'h0, instr_retire};
`endif
      case (state_q)
         ST_IDLE: begin
            if (trap_req) begin
               state_d  = ST_TRAP;
               mepc_d   = trap_pc & 32'hFFFF_FFFC;
               mcause_d = trap_cause;
               mpie_d   = mie_q;
               mie_d    = 1'b0;
            end else if (mret_req) begin
               state_d = ST_MRET;
               mie_d   = mpie_q;
               mpie_d  = 1'b1;
            end else if (wr_ok) begin
               case (csr_addr)
                  ADDR_MSTATUS: begin
                     mie_d  = csr_wdata[3];
                     mpie_d = csr_wdata[7];
                  end
                  ADDR_MTVEC:    mtvec_d    = csr_wdata & 32'hFFFF_FFFC;
                  ADDR_MSCRATCH: mscratch_d = csr_wdata;
                  ADDR_MEPC:     mepc_d     = csr_wdata & 32'hFFFF_FFFC;
                  ADDR_MCAUSE:   mcause_d   = csr_wdata;
`ifdef CSR_COUNTERS_EN
                  ADDR_MCYCLE:    mcycle_d[31:0]    = csr_wdata;
                  ADDR_MCYCLEH:   mcycle_d[63:32]   = csr_wdata;
                  ADDR_MINSTRET:  minstret_d[31:0]  = csr_wdata;
                  ADDR_MINSTRETH: minstret_d[63:32] = csr_wdata;
`endif
                  default: ;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET & 32'hFFFF_FFFC;
         mscratch_q <= 32'h0;
         mepc_q     <= 32'h0;
         mcause_q   <= 32'h0;
`ifdef CSR_COUNTERS_EN
         mcycle_q   <= 64'h0;
         minstret_q <= 64'h0;
`endif
      end else begin
         state_q    <= state_d;
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
`ifdef CSR_COUNTERS_EN
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
`endif
      end
   end

   always_comb begin
      busy           = (state_q != ST_IDLE);
      redirect_valid = busy;
      case (state_q)
         ST_TRAP: redirect_pc = mtvec_q;
         ST_MRET: redirect_pc = mepc_q;
         default: redirect_pc = 32'h0;
      endcase
   end

   assign mie_global = mie_q;

endmodule

// File: doc/csr_file_ctrl.md
Name: csr_file_ctrl

Overview:
- Machine-mode CSR storage and trap sequencer for the core. Sits behind the CSR read-modify-write unit.
- Serves CSR reads and writes at EX: gives the old value to the unit, takes the result on write.
- Sequences trap entry and MRET through a small FSM that saves and restores state and redirects the fetch PC.
- Asserts busy while sequencing so the pipeline stalls.

Parameters:
- HART_ID, 32'h0, value returned by mhartid (0xF14).
- MTVEC_RESET, 32'h0, reset value of mtvec; bits [1:0] are forced to 0.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- csr_addr  in  12  CSR address of current instruction
- csr_rd_en  in  1  read request (csrRead from CSR unit)
- csr_wr_en  in  1  write request (csrWrite from CSR unit)
- csr_wdata  in  32  write value (csrResult from CSR unit)
- csr_rdata  out  32  current CSR value, combinational
- csr_illegal  out  1  unknown address, or write to read-only CSR
- trap_req  in  1  exception/interrupt taken this cycle
- trap_cause  in  32  mcause value for the trap
- trap_pc  in  32  PC of faulting instruction
- mret_req  in  1  MRET at EX
- instr_retire  in  1  one instruction retired this cycle
- redirect_valid  out  1  fetch must jump to redirect_pc
- redirect_pc  out  32  trap vector or mepc
- busy  out  1  FSM not IDLE; pipeline must stall
- mie_global  out  1  mstatus.MIE, to interrupt logic

Behaviour:
- Registers:
  - mstatus (0x300): only MIE bit 3 and MPIE bit 7 implemented; other bits read 0.
  - mtvec (0x305): direct mode only, [1:0]=0.
  - mscratch (0x340): full 32-bit read/write.
  - mepc (0x341): [1:0]=0.
  - mcause (0x342): full 32 bits.
  - mhartid (0xF14): read-only, returns HART_ID.
- Reset: mstatus=0, mtvec=MTVEC_RESET&~3, mscratch=mepc=mcause=0, FSM=IDLE. Outputs: redirect_valid=0, redirect_pc=0, busy=0, mie_global=0.
- Read path: csr_rdata is combinational from csr_addr, independent of csr_rd_en. Unimplemented addresses read 0.
- Write latency: a write takes effect at the next clk edge. A same-cycle read returns the old value. WARL masks are applied on write.
- csr_illegal is combinational, and 1 when either:
  - (csr_rd_en|csr_wr_en) and csr_addr is not implemented, or
  - csr_wr_en and csr_addr is 0xF14.
- An illegal write has no state change.
- FSM states: IDLE, TRAP, MRET.
- IDLE:
  - trap_req → TRAP. On the same edge: mepc<=trap_pc&~3, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
  - else mret_req → MRET. On the same edge: MIE<=MPIE, MPIE<=1.
  - else apply the CSR write if any.
- TRAP: busy=1, redirect_valid=1, redirect_pc=mtvec. Always returns to IDLE after 1 cycle.
- MRET: busy=1, redirect_valid=1, redirect_pc=mepc. Always returns to IDLE after 1 cycle.
- Priority in IDLE: trap_req > mret_req > csr write. A csr write coincident with a trap or MRET is dropped.
- While busy, all requests are ignored: trap_req, mret_req, csr_wr_en, instr_retire counting excepted (see optional feature).
- Redirect timing: redirect_valid is high exactly one cycle, the cycle after the request.
- Reset mid-sequence: rst in TRAP or MRET returns to IDLE next edge with redirect_valid=0.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- When defined:
  - 64-bit mcycle (0xB00 low, 0xB80 high) increments every cycle.
  - 64-bit minstret (0xB02 low, 0xB82 high) increments when instr_retire=1, including while busy.
  - All four addresses are writable 32-bit halves. A written half takes the written value, not value+1, that edge.
  - Low-half carries propagate to the high half. Both counters wrap 2^64-1 → 0.
  - Reset value 0.
- When not defined: the four addresses are unimplemented (read 0, csr_illegal=1).

Test Plan:
- Reset, read 0x305 and 0xF14 with HART_ID=3 → rdata=MTVEC_RESET&~3, then 3; illegal=0.
- Write 0x305=32'h0000_1003, read next cycle → 32'h0000_1000. Same-cycle read → old value.
- MIE=1, trap_req with cause=2, pc=0x84 → next cycle:
  - redirect_valid=1, redirect_pc=mtvec, busy=1
  - mepc=0x84, mcause=2, MIE=0, MPIE=1
  - then idle, redirect_valid=0.
- mret_req after the trap → next cycle redirect_pc=0x84, MIE=1, MPIE=1. A trap_req during MRET busy cycle is ignored.
- trap_req and csr_wr_en to 0x340 in same cycle → mscratch unchanged. Write to 0xF14 → illegal=1, value stays HART_ID. Read 0x7C0 → rdata=0, illegal=1.
- CSR_COUNTERS_EN:
  - Write 0xB00=32'hFFFF_FFFF → two cycles later mcycleh=1, mcycle=0.
  - 5 retire pulses → minstret=5.
